// File: rtl/msk_and_bank_feeder.sv
// Gathers PRNG words into a randomness buffer and issues operands plus one full buffer to a masked AND2 bank.
// Latency: gadget inputs in the fire cycle; out_valid one cycle after fire, aligned with gadget outputs.
// Backpressure: prng_ready low while the buffer is full, in_ready low until it is full; no downstream stall.
module msk_and_bank_feeder #(
    parameter int N      = 8,
    parameter int PRNG_W = 32
) (
    input  logic              clk,
    input  logic              syn_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*N-1:0]    in_a,
    input  logic [2*N-1:0]    in_b,
    input  logic              prng_valid,
    output logic              prng_ready,
    input  logic [PRNG_W-1:0] prng_data,
    output logic [2*N-1:0]    g_ina,
    output logic [2*N-1:0]    g_inb,
    output logic [4*N-1:0]    g_rnd,
    output logic              out_valid
);

    localparam int RW = 4 * N;
    localparam int K  = RW / PRNG_W;
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] K_C = CW'(K);

    logic [CW-1:0] cnt;
    logic [RW-1:0] rnd_buf;
    logic          fire;
    logic          accept;

    // Handshakes depend only on registered state, except reset which forces them low.
    assign in_ready   = !syn_rst && (cnt == K_C);
    assign prng_ready = !syn_rst && (cnt != K_C);
    assign fire       = in_valid && in_ready;
    assign accept     = prng_valid && prng_ready;

    // Gadgets see zeros unless issuing, so stale shares or randomness never leak.
    assign g_ina = fire ? in_a : '0;
    assign g_inb = fire ? in_b : '0;
    assign g_rnd = fire ? rnd_buf : '0;

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            cnt       <= '0;
            rnd_buf   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= fire;
            if (fire) begin
                cnt     <= '0;
                rnd_buf <= '0;
            end else if (accept) begin
                for (int w = 0; w < K; w++) begin
                    if (cnt == CW'(w)) begin
                        rnd_buf[w*PRNG_W +: PRNG_W] <= prng_data;
                    end
                end
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
